// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator output path.
package acc_pkg;

    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_RUN   = 2'd1,
        MM_DRAIN = 2'd2
    } mm_state_e;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

endpackage

// File: rtl/requant_int8.sv
// Combinational ReLU, round-half-up arithmetic shift and int8 saturation.
module requant_int8
    import acc_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic signed [ACC_W-1:0] x,
    input  logic        [4:0]       shift,
    input  logic                    relu_en,
    output logic        [7:0]       q
);

    localparam logic signed [ACC_W:0] SatHi = (ACC_W+1)'(INT8_MAX);
    localparam logic signed [ACC_W:0] SatLo = (ACC_W+1)'(INT8_MIN);

    logic signed [ACC_W:0] xe;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        xe  = {x[ACC_W-1], x};
        rnd = '0;
        if (relu_en && x[ACC_W-1]) begin
            xe = '0;
        end
        if (shift != 5'd0) begin
            rnd = (ACC_W+1)'(1) << (shift - 5'd1);
        end
        sum = xe + rnd;
        r   = sum >>> shift;
        if (r > SatHi) begin
            q = SatHi[7:0];
        end else if (r < SatLo) begin
            q = SatLo[7:0];
        end else begin
            q = r[7:0];
        end
    end

endmodule

// File: rtl/sirv_gnrl_pipe_stage.sv
// Single-entry valid/ready pipeline stage with synchronous reset and flush.
module sirv_gnrl_pipe_stage #(
    parameter int unsigned CUT_READY = 0,
    parameter int unsigned DP        = 1,
    parameter int unsigned DW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    if (DP == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst_n, flush};
        assign o_vld = i_vld;
        assign i_rdy = o_rdy;
        assign o_dat = i_dat;
    end else begin : g_reg
        logic          vld_q, vld_d;
        logic [DW-1:0] dat_q, dat_d;
        logic          vld_set, vld_clr;

        // Load on input handshake, empty on output handshake; flush wins.
        always_comb begin
            vld_clr = vld_q & o_rdy;
            i_rdy   = (CUT_READY != 0) ? ~vld_q : (~vld_q | vld_clr);
            vld_set = i_vld & i_rdy;
            vld_d   = vld_q;
            dat_d   = dat_q;
            if (flush) begin
                vld_d = 1'b0;
                dat_d = '0;
            end else begin
                if (vld_set) begin
                    vld_d = 1'b1;
                    dat_d = i_dat;
                end else if (vld_clr) begin
                    vld_d = 1'b0;
                end
            end
        end

        // Stage register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign o_vld = vld_q;
        assign o_dat = dat_q;
    end

endmodule

// File: rtl/map_merger.sv
// Requantizes accumulator results to int8 and packs four per 32-bit output word.
module map_merger
    import acc_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    conv_start,
    input  logic        [7:0]       out_ch,
    input  logic        [15:0]      map_size,
    input  logic        [4:0]       quant_shift,
    input  logic                    relu_en,
    input  logic signed [ACC_W-1:0] core2map_merger_data,
    input  logic                    core2map_merger_vld,
    output logic                    core2map_merger_rdy,
    output logic        [31:0]      map_merger2omap_biu_data,
    output logic                    map_merger2omap_biu_vld,
    input  logic                    map_merger2omap_biu_rdy,
    output logic                    merge_done
);

    mm_state_e        state_q, state_d;
    logic [CNT_W-1:0] total_el_q, total_el_d;
    logic [CNT_W-1:0] total_wd_q, total_wd_d;
    logic [CNT_W-1:0] el_cnt_q, el_cnt_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [4:0]       shift_q, shift_d;
    logic             relu_q, relu_d;
    logic             zero_done_q, zero_done_d;

    // Stage 1: requantized byte plus a flag marking the layer's final element.
    logic             s1_vld_q, s1_vld_d;
    logic [7:0]       s1_byte_q, s1_byte_d;
    logic             s1_last_q, s1_last_d;

    // Stage 2 front half: partially filled word and its lane pointer.
    logic [1:0]       lane_q, lane_d;
    logic [31:0]      pack_q, pack_d;

    logic [CNT_W-1:0] cfg_total;
    logic [CNT_W:0]   cfg_words_ext;
    logic [CNT_W-1:0] cfg_words;
    logic [7:0]       q_byte;
    logic             pipe_i_vld, pipe_i_rdy, pipe_o_vld;
    logic [31:0]      pipe_i_dat;
    logic             word_push, s1_pop, s1_adv;
    logic             in_hs, out_hs, last_word;

    requant_int8 #(
        .ACC_W (ACC_W)
    ) u_requant (
        .x       (core2map_merger_data),
        .shift   (shift_q),
        .relu_en (relu_q),
        .q       (q_byte)
    );

    sirv_gnrl_pipe_stage #(
        .CUT_READY (0),
        .DP        (1),
        .DW        (32)
    ) u_out_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (conv_start),
        .i_vld (pipe_i_vld),
        .i_rdy (pipe_i_rdy),
        .i_dat (pipe_i_dat),
        .o_vld (pipe_o_vld),
        .o_rdy (map_merger2omap_biu_rdy),
        .o_dat (map_merger2omap_biu_data)
    );

    // Handshake qualifiers, word assembly and ready generation.
    always_comb begin
        cfg_total     = CNT_W'(map_size) * CNT_W'(out_ch);
        cfg_words_ext = {1'b0, cfg_total} + (CNT_W+1)'(3);
        cfg_words     = CNT_W'(cfg_words_ext >> 2);

        // Only the byte completing a word needs space in the output register.
        word_push  = s1_vld_q && ((lane_q == 2'd3) || s1_last_q);
        s1_pop     = s1_vld_q && (!word_push || pipe_i_rdy);
        s1_adv     = !s1_vld_q || s1_pop;
        pipe_i_vld = word_push && !conv_start;
        pipe_i_dat = pack_q | (32'(s1_byte_q) << {lane_q, 3'b000});

        core2map_merger_rdy = (state_q == MM_RUN) && (el_cnt_q != total_el_q) && s1_adv;
        in_hs     = core2map_merger_vld && core2map_merger_rdy && !conv_start;
        out_hs    = pipe_o_vld && map_merger2omap_biu_rdy;
        last_word = (wd_cnt_q == total_wd_q - CNT_W'(1));

        merge_done = zero_done_q ||
                     ((state_q == MM_DRAIN) && out_hs && last_word && !conv_start);

        map_merger2omap_biu_vld = pipe_o_vld;
    end

    // Next-state for the FSM, counters, stage 1 and the pack register.
    always_comb begin
        state_d     = state_q;
        total_el_d  = total_el_q;
        total_wd_d  = total_wd_q;
        el_cnt_d    = el_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        zero_done_d = 1'b0;
        s1_vld_d    = s1_vld_q;
        s1_byte_d   = s1_byte_q;
        s1_last_d   = s1_last_q;
        lane_d      = lane_q;
        pack_d      = pack_q;

        if (conv_start) begin
            // New layer or abort: drop everything in flight, no done for the old layer.
            total_el_d  = cfg_total;
            total_wd_d  = cfg_words;
            shift_d     = quant_shift;
            relu_d      = relu_en;
            el_cnt_d    = '0;
            wd_cnt_d    = '0;
            s1_vld_d    = 1'b0;
            s1_byte_d   = '0;
            s1_last_d   = 1'b0;
            lane_d      = '0;
            pack_d      = '0;
            zero_done_d = (cfg_total == '0);
            state_d     = (cfg_total == '0) ? MM_IDLE : MM_RUN;
        end else begin
            if (s1_pop) begin
                s1_vld_d = 1'b0;
                if (word_push) begin
                    lane_d = '0;
                    pack_d = '0;
                end else begin
                    pack_d[{lane_q, 3'b000} +: 8] = s1_byte_q;
                    lane_d = lane_q + 2'd1;
                end
            end
            if (in_hs) begin
                s1_vld_d  = 1'b1;
                s1_byte_d = q_byte;
                s1_last_d = (el_cnt_q + CNT_W'(1) == total_el_q);
                el_cnt_d  = el_cnt_q + CNT_W'(1);
            end
            if (out_hs) begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                MM_IDLE: state_d = MM_IDLE;
                MM_RUN: begin
                    if (in_hs && (el_cnt_q + CNT_W'(1) == total_el_q)) begin
                        state_d = MM_DRAIN;
                    end
                end
                MM_DRAIN: begin
                    if (out_hs && last_word) begin
                        state_d = MM_IDLE;
                    end
                end
                default: state_d = MM_IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MM_IDLE;
            total_el_q  <= '0;
            total_wd_q  <= '0;
            el_cnt_q    <= '0;
            wd_cnt_q    <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            zero_done_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_byte_q   <= '0;
            s1_last_q   <= 1'b0;
            lane_q      <= '0;
            pack_q      <= '0;
        end else begin
            state_q     <= state_d;
            total_el_q  <= total_el_d;
            total_wd_q  <= total_wd_d;
            el_cnt_q    <= el_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            zero_done_q <= zero_done_d;
            s1_vld_q    <= s1_vld_d;
            s1_byte_q   <= s1_byte_d;
            s1_last_q   <= s1_last_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
        end
    end

endmodule

// File: doc/map_merger.md
# map_merger

Requantizes the conv core's 32-bit signed accumulator results to int8, applies optional ReLU, and packs four consecutive results into one 32-bit word for `omap_biu`. It sits between the conv core output and `omap_biu`, and drives `omap_biu` through a valid/ready stream. It counts elements per layer, zero-pads a trailing partial word, and pulses `merge_done` once the last word has been handed off.

## Interface
Parameters:
- `ACC_W`, 32: accumulator input width.
- `CNT_W`, 24: element/word counter width (covers 65535×255).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `conv_start` in 1: one-cycle layer start pulse; latches the config below.
- `out_ch` in 8: output channels.
- `map_size` in 16: pixels per output channel.
- `quant_shift` in 5: arithmetic right-shift amount.
- `relu_en` in 1: clamp negatives to 0.
- `core2map_merger_data` in ACC_W: signed accumulator result.
- `core2map_merger_vld` in 1: input valid.
- `core2map_merger_rdy` out 1: input ready.
- `map_merger2omap_biu_data` out 32: packed int8×4, first element in [7:0].
- `map_merger2omap_biu_vld` out 1: output valid.
- `map_merger2omap_biu_rdy` in 1: output ready.
- `merge_done` out 1: one-cycle pulse after the last word handshake.

## Operation
- States are `IDLE`, `RUN`, `DRAIN`.
  - `IDLE` → `RUN` on `conv_start`.
  - `RUN` → `DRAIN` when the accepted element count reaches `total_el`.
  - `DRAIN` → `IDLE` on the last output handshake, asserting `merge_done` in that same cycle.
- At `conv_start`:
  - `total_el = map_size*out_ch` (CNT_W, registered).
  - `total_wd = ceil(total_el/4)`.
  - `quant_shift` and `relu_en` are latched.
- If `total_el == 0` at `conv_start`: go to `IDLE` next cycle and pulse `merge_done`.
- Per-element requantization, with x = the input:
  - If `relu_en` and x < 0, then x = 0.
  - If shift > 0, then r = (x + (1 << (shift-1))) >>> shift. Use an ACC_W+1 intermediate so the rounding add cannot overflow.
  - If shift = 0, then r = x.
  - Saturate r to [-128, 127].
- Packing:
  - The lane counter (0..3) selects the byte of the pack register.
  - Lane 3, or the final element, moves the word to the output register. Unfilled upper lanes are 0.
  - The lane counter resets to 0 after each word.
- Input ready:
  - `core2map_merger_rdy` = state==RUN && stage-1 slot can advance.
  - Input is never accepted in `IDLE` or `DRAIN`, or after `total_el` elements have been accepted.
- Counters:
  - `el_cnt` increments on each input handshake.
  - `wd_cnt` increments on each output handshake.
  - The last word is `wd_cnt == total_wd-1`.
- `conv_start` in `RUN` or `DRAIN` aborts the layer:
  - Stage 1, the pack register, the output register and all counters are cleared.
  - The new config is latched and the block enters `RUN`.
  - No `merge_done` is produced for the aborted layer.

## Timing
- Reset values: `core2map_merger_rdy`=0, `map_merger2omap_biu_vld`=0, `map_merger2omap_biu_data`=0, `merge_done`=0, state `IDLE`, all counters 0.
- Stage 1 registers the requantized byte, one cycle after the input handshake.
- Stage 2 is the pack register plus the output register.
  - The output is valid one cycle after the stage-1 byte that completes a word.
  - Input handshake of the 4th element at cycle N gives output valid at N+2.
- Throughput is one element per cycle while the output is not stalled, giving one word per 4 cycles sustained.
- Output hold rule: while vld=1 and rdy=0, data and vld hold stable.
- Backpressure:
  - Input ready deasserts when stage 1 holds a byte that cannot enter the pack register.
  - This happens only when a completed word is pending in the output register and not being accepted this cycle.
  - The pack register accepts lanes 0..2 regardless of output-register state.
- `merge_done` asserts in the same cycle as the final vld&&rdy and is deasserted the next cycle.
- `conv_start` together with a handshake: the handshake is discarded and `conv_start` wins.

## Structure
- Shared package `acc_pkg`:
  - State encoding `MM_IDLE`/`MM_RUN`/`MM_DRAIN`.
  - `INT8_MAX`=127, `INT8_MIN`=-128.
- Sub-module `requant_int8`: combinational ReLU/round/shift/saturate.
  - Ports: `x[ACC_W]`, `shift[5]`, `relu_en` → `q[8]`.
  - Instantiated once ahead of the stage-1 register.
- Output register: reuse `sirv_gnrl_pipe_stage` with CUT_READY=0, DP=1, DW=32.

## Test plan
1. `map_size`=4, `out_ch`=1, shift=0, relu off; inputs 1, -1, 127, 200 → one word 0x7F7FFF01, `merge_done` in the same cycle as its handshake.
2. Shift=4, inputs 24, 23, -24, -40000, relu off → bytes 2, 1, -1 (0xFF), -128 (0x80); word 0x80FF0102.
3. Relu on, shift=0, inputs -5, 3, -100, 0 → word 0x00000300.
4. `map_size`=3, `out_ch`=2 (6 elements), inputs 1..6 → words 0x04030201 and 0x00000605; `merge_done` after the 2nd handshake; input ready low after the 6th element.
5. Output rdy held low for 10 cycles with 12 elements streaming:
   - No data loss, and output data holds stable.
   - Input ready drops within 2 cycles of the stall.
   - The 3 words appear in order.
6. `conv_start` reissued mid-layer after 5 of 16 elements:
   - No `merge_done` for the aborted layer.
   - The new layer's first word contains only post-restart inputs.
   - Synchronous reset mid-stream returns all outputs to reset values in the next cycle.
